// File: rtl/dpb_pkg.sv
// Shared definitions for the DPB packet-slot handoff: slot descriptor layout
// and the {slot, word} address split used by both the writer and the reader.
package dpb_pkg;

   localparam int SLOT_W     = 4;
   localparam int SLOT_WORDS = 128;
   localparam int WORD_W     = $clog2(SLOT_WORDS);
   localparam int ADDR_W     = SLOT_W + WORD_W;

   localparam logic [WORD_W-1:0] PAYLOAD_BASE = 7'd1;

   typedef struct packed {
      logic [7:0] udp_rank;
      logic [3:0] buf_rank;
      logic [6:0] cnt128;
      logic [5:0] bytecnt;
      logic       frame_last;
   } desc_t;

   function automatic logic [ADDR_W-1:0] dpb_addr(input logic [SLOT_W-1:0] slot,
                                                   input logic [WORD_W-1:0] word);
      return {slot, word};
   endfunction

endpackage

// File: rtl/dpb_desc_handoff.sv
// Descriptor handoff to the UDP-side slot reader: reader-idle token, one
// pending descriptor, single-cycle request and held descriptor outputs.
module dpb_desc_handoff
   import dpb_pkg::*;
(
   input  logic  i_clk,
   input  logic  i_rst,
   input  logic  i_cmpl_valid,
   input  desc_t i_cmpl_desc,
   input  logic  i_wr_down,
   output logic  o_req,
   output desc_t o_desc,
   output logic  o_pend_full
);

   logic  r_token;
   logic  r_pend_valid;
   desc_t r_pend;
   logic  r_req;
   desc_t r_desc;
   logic  w_issue_new;
   logic  w_issue_pend;

   // A completion coinciding with wr_down is parked so it issues one cycle later.
   always_comb begin
      w_issue_pend = r_pend_valid && (r_token || i_wr_down);
      w_issue_new  = i_cmpl_valid && r_token && !r_pend_valid && !i_wr_down;
   end

   // Token, pending slot and the request/descriptor output registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_token      <= 1'b1;
         r_pend_valid <= 1'b0;
         r_pend       <= '0;
         r_req        <= 1'b0;
         r_desc       <= '0;
      end else begin
         r_req <= w_issue_new || w_issue_pend;
         if (w_issue_pend) begin
            r_desc <= r_pend;
         end else if (w_issue_new) begin
            r_desc <= i_cmpl_desc;
         end
         if (i_cmpl_valid && !w_issue_new) begin
            r_pend_valid <= 1'b1;
            r_pend       <= i_cmpl_desc;
         end else if (w_issue_pend) begin
            r_pend_valid <= 1'b0;
         end
         if (w_issue_new || w_issue_pend) begin
            r_token <= 1'b0;
         end else if (i_wr_down) begin
            r_token <= 1'b1;
         end
      end
   end

   assign o_req       = r_req;
   assign o_desc      = r_desc;
   assign o_pend_full = r_pend_valid;

endmodule

// File: rtl/dpb_master_fill.sv
// Writer side of the DPB packet-slot handoff: fills one 128-word slot per
// packet on port A and publishes its descriptor to the slot reader.
module dpb_master_fill
   import dpb_pkg::*;
#(
   parameter int PKT_WORDS = 90
) (
   input  logic          i_pclk,
   input  logic          i_rst,
   input  logic          i_data_valid,
   input  logic [127:0]  i_data,
   input  logic          i_data_last,
   input  logic [4:0]    i_data_bytes,
   input  logic          i_frame_last,
   output logic          o_data_ready,
   output logic [127:0]  o_dpb_wr_a_wr_data,
   output logic [10:0]   o_dpb_wr_a_addr,
   output logic          o_dpb_wr_a_clk,
   output logic          o_dpb_wr_a_cea,
   output logic          o_dpb_wr_a_ocea,
   output logic          o_dpb_wr_a_rst_n,
   output logic          o_dpb_wr_a_wr_en,
   output logic          o_ddr3_master_wr_req,
   output logic          o_ddr3_master_wr_frame_down,
   output logic [7:0]    o_ddr3_master_wr_udp_rank,
   output logic [3:0]    o_ddr3_master_wr_buf_rank,
   output logic [6:0]    o_ddr3_master_wr_buf_128cnt,
   output logic [5:0]    o_ddr3_master_wr_buf_Bytecnt,
   input  logic          i_ddr3_master_wr_down,
   output logic          o_pkt_trunc
);

   localparam logic [WORD_W-1:0] MAX_WORD = WORD_W'(PKT_WORDS);

   logic [SLOT_W-1:0] r_slot;
   logic [WORD_W-1:0] r_word;
   logic [7:0]        r_udp_rank;
   logic              r_run;
   logic              r_cmpl_valid;
   desc_t             r_cmpl_desc;
   logic [127:0]      r_wr_data;
   logic [ADDR_W-1:0] r_wr_addr;
   logic              r_wr_en;
   logic              r_trunc;

   logic              w_pend_full;
   logic              w_ready;
   logic              w_accept;
   logic              w_at_max;
   logic              w_end;
   logic              w_full16;
   logic              w_frame_last;
   logic [WORD_W-1:0] w_cnt128;
   logic [5:0]        w_bytecnt;
   desc_t             w_desc;
   desc_t             w_out_desc;

   // Beat acceptance and descriptor of the packet closing on this beat.
   always_comb begin
      w_ready      = r_run && !r_cmpl_valid && !w_pend_full;
      w_accept     = i_data_valid && w_ready;
      w_at_max     = (r_word == MAX_WORD);
      w_end        = i_data_last || w_at_max;
      w_full16     = w_at_max || (i_data_bytes == 5'd0) || (i_data_bytes >= 5'd16);
      w_frame_last = i_data_last && i_frame_last;
      w_cnt128     = w_full16 ? r_word : (r_word - 7'd1);
      w_bytecnt    = w_full16 ? 6'd0 : {1'b0, i_data_bytes};
      w_desc.udp_rank   = r_udp_rank;
      w_desc.buf_rank   = r_slot;
      w_desc.cnt128     = w_cnt128;
      w_desc.bytecnt    = w_bytecnt;
      w_desc.frame_last = w_frame_last;
   end

   // Slot fill state and the registered port-A write.
   always_ff @(posedge i_pclk) begin
      if (i_rst) begin
         r_run        <= 1'b0;
         r_slot       <= '0;
         r_word       <= PAYLOAD_BASE;
         r_udp_rank   <= 8'd0;
         r_cmpl_valid <= 1'b0;
         r_cmpl_desc  <= '0;
         r_wr_data    <= '0;
         r_wr_addr    <= '0;
         r_wr_en      <= 1'b0;
         r_trunc      <= 1'b0;
      end else begin
         r_run        <= 1'b1;
         r_wr_en      <= w_accept;
         r_cmpl_valid <= w_accept && w_end;
         r_trunc      <= w_accept && w_at_max;
         if (w_accept) begin
            r_wr_data <= i_data;
            r_wr_addr <= dpb_addr(r_slot, r_word);
            if (w_end) begin
               r_cmpl_desc <= w_desc;
               r_slot      <= r_slot + 4'd1;
               r_word      <= PAYLOAD_BASE;
               r_udp_rank  <= w_frame_last ? 8'd0 : (r_udp_rank + 8'd1);
            end else begin
               r_word <= r_word + 7'd1;
            end
         end
      end
   end

   dpb_desc_handoff u_handoff (
      .i_clk        (i_pclk),
      .i_rst        (i_rst),
      .i_cmpl_valid (r_cmpl_valid),
      .i_cmpl_desc  (r_cmpl_desc),
      .i_wr_down    (i_ddr3_master_wr_down),
      .o_req        (o_ddr3_master_wr_req),
      .o_desc       (w_out_desc),
      .o_pend_full  (w_pend_full)
   );

   assign o_data_ready                 = w_ready;
   assign o_dpb_wr_a_wr_data           = r_wr_data;
   assign o_dpb_wr_a_addr              = r_wr_addr;
   assign o_dpb_wr_a_wr_en             = r_wr_en;
   assign o_dpb_wr_a_clk               = i_pclk;
   assign o_dpb_wr_a_cea               = 1'b1;
   assign o_dpb_wr_a_ocea              = 1'b1;
   assign o_dpb_wr_a_rst_n             = 1'b0;
   assign o_pkt_trunc                  = r_trunc;
   assign o_ddr3_master_wr_frame_down  = w_out_desc.frame_last;
   assign o_ddr3_master_wr_udp_rank    = w_out_desc.udp_rank;
   assign o_ddr3_master_wr_buf_rank    = w_out_desc.buf_rank;
   assign o_ddr3_master_wr_buf_128cnt  = w_out_desc.cnt128;
   assign o_ddr3_master_wr_buf_Bytecnt = w_out_desc.bytecnt;

endmodule

// File: tb/tb_dpb_master_fill.sv
// Directed bench for dpb_master_fill: a packet table plus hand-written
// sequences for backpressure, truncation, slot wrap and mid-packet reset.
module tb_dpb_master_fill;

   logic         clk = 1'b0;
   logic         i_rst = 1'b1;
   logic         i_data_valid = 1'b0;
   logic [127:0] i_data = '0;
   logic         i_data_last = 1'b0;
   logic [4:0]   i_data_bytes = 5'd0;
   logic         i_frame_last = 1'b0;
   logic         i_wr_down = 1'b0;
   logic         o_data_ready;
   logic [127:0] o_wr_data;
   logic [10:0]  o_addr;
   logic         o_wclk, o_cea, o_ocea, o_rst_n, o_wr_en;
   logic         o_req, o_fd;
   logic [7:0]   o_udp;
   logic [3:0]   o_buf;
   logic [6:0]   o_cnt;
   logic [5:0]   o_bc;
   logic         o_trunc;

   int           checks = 0;
   int           errors = 0;
   int           beat_k = 0;
   logic [3:0]   exp_slot = 4'd0;
   logic [6:0]   exp_word = 7'd1;

   typedef struct {
      int         n;
      logic [4:0] nb;
      logic       fl;
      logic [25:0] exp_desc;
   } vec_t;
   vec_t tbl [6];

   always #5 clk = ~clk;

   dpb_master_fill #(.PKT_WORDS(90)) dut (
      .i_pclk                       (clk),
      .i_rst                        (i_rst),
      .i_data_valid                 (i_data_valid),
      .i_data                       (i_data),
      .i_data_last                  (i_data_last),
      .i_data_bytes                 (i_data_bytes),
      .i_frame_last                 (i_frame_last),
      .o_data_ready                 (o_data_ready),
      .o_dpb_wr_a_wr_data           (o_wr_data),
      .o_dpb_wr_a_addr              (o_addr),
      .o_dpb_wr_a_clk               (o_wclk),
      .o_dpb_wr_a_cea               (o_cea),
      .o_dpb_wr_a_ocea              (o_ocea),
      .o_dpb_wr_a_rst_n             (o_rst_n),
      .o_dpb_wr_a_wr_en             (o_wr_en),
      .o_ddr3_master_wr_req         (o_req),
      .o_ddr3_master_wr_frame_down  (o_fd),
      .o_ddr3_master_wr_udp_rank    (o_udp),
      .o_ddr3_master_wr_buf_rank    (o_buf),
      .o_ddr3_master_wr_buf_128cnt  (o_cnt),
      .o_ddr3_master_wr_buf_Bytecnt (o_bc),
      .i_ddr3_master_wr_down        (i_wr_down),
      .o_pkt_trunc                  (o_trunc)
   );

   function automatic logic [25:0] mk(input logic [7:0] udp, input logic [3:0] bufr,
                                      input logic [6:0] cnt, input logic [5:0] bc,
                                      input logic fd);
      return {udp, bufr, cnt, bc, fd};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic chk_desc(input string nm, input logic [25:0] exp);
      chk(nm, {o_udp, o_buf, o_cnt, o_bc, o_fd}, exp);
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      i_data_valid = 1'b0;
      i_wr_down = 1'b0;
      tick();
      tick();
      chk("rst_data", o_wr_data, 128'd0);
      chk("rst_ctl", {o_data_ready, o_addr, o_wr_en, o_req, o_fd, o_udp, o_buf, o_cnt, o_bc, o_trunc}, 0);
      chk("rst_tie", {o_cea, o_ocea, o_rst_n}, 3'b110);
      i_rst = 1'b0;
      exp_slot = 4'd0;
      exp_word = 7'd1;
   endtask

   task automatic send_beat(input logic last, input logic [4:0] nb, input logic fl,
                            input logic exp_trunc);
      int guard;
      logic [127:0] d;
      guard = 0;
      d = {beat_k, 32'hDEADBEEF ^ beat_k, beat_k * 3, 32'hC0FFEE00 + beat_k};
      beat_k++;
      i_data_valid = 1'b1;
      i_data = d;
      i_data_last = last;
      i_data_bytes = nb;
      i_frame_last = fl;
      while (!o_data_ready && guard < 50) begin
         tick();
         guard++;
      end
      if (!o_data_ready) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout actual=0 expected=1");
      end
      tick();
      i_data_valid = 1'b0;
      i_data_last = 1'b0;
      chk("wr_en", o_wr_en, 1'b1);
      chk("wr_addr", o_addr, {exp_slot, exp_word});
      chk("wr_data", o_wr_data, d);
      chk("trunc", o_trunc, exp_trunc);
      if (last || exp_trunc) begin
         exp_slot = exp_slot + 4'd1;
         exp_word = 7'd1;
      end else begin
         exp_word = exp_word + 7'd1;
      end
   endtask

   // Leaves the bench at t+1 of the last beat, with ready checked low.
   task automatic send_pkt(input int n, input logic [4:0] nb, input logic fl);
      for (int i = 0; i < n; i++) begin
         send_beat(i == n - 1, nb, fl, 1'b0);
      end
      chk("ready_t1", o_data_ready, 1'b0);
   endtask

   task automatic down_pulse();
      i_wr_down = 1'b1;
      tick();
      i_wr_down = 1'b0;
      chk("req_single", o_req, 1'b0);
   endtask

   initial begin
      tbl[0] = '{3, 5'd5,  1'b0, mk(8'd0, 4'd0, 7'd2, 6'd5,  1'b0)};
      tbl[1] = '{1, 5'd0,  1'b1, mk(8'd1, 4'd1, 7'd1, 6'd0,  1'b1)};
      tbl[2] = '{2, 5'd16, 1'b0, mk(8'd0, 4'd2, 7'd2, 6'd0,  1'b0)};
      tbl[3] = '{4, 5'd15, 1'b0, mk(8'd1, 4'd3, 7'd3, 6'd15, 1'b0)};
      tbl[4] = '{1, 5'd1,  1'b1, mk(8'd2, 4'd4, 7'd0, 6'd1,  1'b1)};
      tbl[5] = '{5, 5'd8,  1'b0, mk(8'd0, 4'd5, 7'd4, 6'd8,  1'b0)};

      // Table of single packets with a prompt reader.
      do_reset();
      for (int v = 0; v < 6; v++) begin
         send_pkt(tbl[v].n, tbl[v].nb, tbl[v].fl);
         tick();
         chk("tbl_req", o_req, 1'b1);
         chk_desc("tbl_desc", tbl[v].exp_desc);
         down_pulse();
         chk_desc("tbl_desc_hold", tbl[v].exp_desc);
      end

      // Reader withholds wr_down: second descriptor waits in pending.
      do_reset();
      send_pkt(2, 5'd16, 1'b0);
      tick();
      chk("bp_req_a", o_req, 1'b1);
      chk_desc("bp_desc_a", mk(8'd0, 4'd0, 7'd2, 6'd0, 1'b0));
      send_pkt(1, 5'd3, 1'b0);
      tick();
      chk("bp_req_withheld", o_req, 1'b0);
      chk("bp_ready_pend", o_data_ready, 1'b0);
      tick();
      tick();
      chk("bp_ready_pend2", o_data_ready, 1'b0);
      chk_desc("bp_desc_held", mk(8'd0, 4'd0, 7'd2, 6'd0, 1'b0));
      i_wr_down = 1'b1;
      tick();
      i_wr_down = 1'b0;
      chk("bp_req_d1", o_req, 1'b1);
      chk_desc("bp_desc_b", mk(8'd1, 4'd1, 7'd0, 6'd3, 1'b0));
      chk("bp_ready_d1", o_data_ready, 1'b1);

      // Completion coinciding with wr_down issues one cycle later.
      send_pkt(1, 5'd7, 1'b1);
      i_wr_down = 1'b1;
      tick();
      i_wr_down = 1'b0;
      chk("sim_req_wait", o_req, 1'b0);
      chk("sim_ready_low", o_data_ready, 1'b0);
      tick();
      chk("sim_req", o_req, 1'b1);
      chk_desc("sim_desc", mk(8'd2, 4'd2, 7'd0, 6'd7, 1'b1));
      chk("sim_ready", o_data_ready, 1'b1);

      // 100 beats without last: forced close at word 90, remainder into slot 1.
      do_reset();
      for (int i = 0; i < 100; i++) begin
         send_beat(1'b0, 5'd3, 1'b1, i == 89);
         if (i == 89) begin
            chk("tr_ready_t1", o_data_ready, 1'b0);
            tick();
            chk("tr_req", o_req, 1'b1);
            chk_desc("tr_desc", mk(8'd0, 4'd0, 7'd90, 6'd0, 1'b0));
            down_pulse();
         end
      end

      // 17 one-word packets with a prompt reader: slot wraps 15 -> 0.
      do_reset();
      for (int p = 0; p < 17; p++) begin
         send_pkt(1, 5'd4, 1'b0);
         tick();
         chk("wrap_req", o_req, 1'b1);
         chk_desc("wrap_desc", mk(p[7:0], p[3:0], 7'd0, 6'd4, 1'b0));
         down_pulse();
      end

      // Reset at word 40 abandons the packet; next packet restarts slot 0.
      do_reset();
      for (int i = 0; i < 40; i++) begin
         send_beat(1'b0, 5'd0, 1'b0, 1'b0);
      end
      do_reset();
      tick();
      chk("mr_no_req", o_req, 1'b0);
      send_pkt(2, 5'd9, 1'b0);
      tick();
      chk("mr_req", o_req, 1'b1);
      chk_desc("mr_desc", mk(8'd0, 4'd0, 7'd1, 6'd9, 1'b0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
